// File: rtl/wbs_sram.sv
// wbs_sram: Wishbone B3 classic slave over a byte-lane-writable word RAM with wait states.
// Optional macro WBS_SRAM_ERR_EN adds wb_err_o and rejects misaligned or out-of-range requests.
//
// state  | meaning
// S_IDLE | no transfer; cyc&stb latches a request
// S_WAIT | counting wait states; dropping cyc/stb aborts
// S_ACK  | one-cycle ack (or err) pulse, then back to idle
module wbs_sram #(
   parameter int ADDR_WIDTH  = 12,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        busy_o
`ifdef WBS_SRAM_ERR_EN
  ,output logic        wb_err_o
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t                  state, state_nxt;
   logic [3:0]              cnt, cnt_nxt;
   logic                    req, req_bad, latch, do_access, wr_en;
   logic [ADDR_WIDTH-1:0]   req_word, acc_word;
   logic                    req_we, acc_we;
   logic [3:0]              req_sel, acc_sel;
   logic [31:0]             req_dat, acc_dat;
   logic                    req_err, acc_err;
   logic                    unused_adr;

   logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

   assign req        = wb_cyc_i & wb_stb_i;
   assign unused_adr = ^{wb_adr_i[31:ADDR_WIDTH+2], wb_adr_i[1:0]};

`ifdef WBS_SRAM_ERR_EN
   assign req_bad = (wb_adr_i[1:0] != 2'b00) || (wb_adr_i[31:ADDR_WIDTH+2] != '0);
`else
   assign req_bad = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      latch     = 1'b0;
      do_access = 1'b0;
      case (state)
         S_IDLE: begin
            if (req) begin
               latch = 1'b1;
               if (WAIT_STATES == 0) begin
                  state_nxt = S_ACK;
                  do_access = 1'b1;
               end else begin
                  state_nxt = S_WAIT;
                  cnt_nxt   = WS_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (!req) begin
               state_nxt = S_IDLE;
            end else if (cnt == 4'd0) begin
               state_nxt = S_ACK;
               do_access = 1'b1;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         S_ACK:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // With zero wait states the access happens on the sampling edge, before the request registers load.
   always_comb begin
      if (state == S_IDLE) begin
         acc_word = wb_adr_i[ADDR_WIDTH+1:2];
         acc_we   = wb_we_i;
         acc_sel  = wb_sel_i;
         acc_dat  = wb_dat_i;
         acc_err  = req_bad;
      end else begin
         acc_word = req_word;
         acc_we   = req_we;
         acc_sel  = req_sel;
         acc_dat  = req_dat;
         acc_err  = req_err;
      end
   end

   assign wr_en = do_access & acc_we & ~acc_err & rst;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         cnt      <= 4'd0;
         req_word <= '0;
         req_we   <= 1'b0;
         req_sel  <= 4'd0;
         req_dat  <= 32'h0;
         req_err  <= 1'b0;
         wb_dat_o <= 32'h0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (latch) begin
            req_word <= wb_adr_i[ADDR_WIDTH+1:2];
            req_we   <= wb_we_i;
            req_sel  <= wb_sel_i;
            req_dat  <= wb_dat_i;
            req_err  <= req_bad;
         end
         if (do_access && !acc_we && !acc_err) begin
            wb_dat_o <= mem[acc_word];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_sel[i]) begin
               mem[acc_word][8*i +: 8] <= acc_dat[8*i +: 8];
            end
         end
      end
   end

   assign wb_ack_o = (state == S_ACK) && !req_err;
   assign busy_o   = (state != S_IDLE);

`ifdef WBS_SRAM_ERR_EN
   assign wb_err_o = (state == S_ACK) && req_err;
`endif

endmodule

// File: tb/tb_wbs_sram.sv
// tb_wbs_sram: self-checking bench for wbs_sram using three instances with 0, 1 and 3 wait states.
// Honors WBS_SRAM_ERR_EN when the design is built with it.
module tb_wbs_sram;

   localparam int AW = 12;
`ifdef WBS_SRAM_ERR_EN
   localparam bit ERR_BUILD = 1'b1;
`else
   localparam bit ERR_BUILD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cyc  [3];
   logic        stb  [3];
   logic        we   [3];
   logic [3:0]  sel  [3];
   logic [31:0] adr  [3];
   logic [31:0] dati [3];
   logic [31:0] dato [3];
   logic        ack  [3];
   logic        busy [3];
   logic        err  [3];

   int          total = 0;
   int          bad   = 0;
   int          ws_of [3] = '{0, 1, 3};
   logic [31:0] last_rd [3];
   logic [31:0] mdl [3][16];

   always #5 clk = ~clk;

   wbs_sram #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .rst(rst), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
      .wb_sel_i(sel[0]), .wb_adr_i(adr[0]), .wb_dat_i(dati[0]), .wb_dat_o(dato[0]),
      .wb_ack_o(ack[0]), .busy_o(busy[0])
`ifdef WBS_SRAM_ERR_EN
      , .wb_err_o(err[0])
`endif
   );
   wbs_sram #(.ADDR_WIDTH(AW), .WAIT_STATES(1)) u_ws1 (
      .clk(clk), .rst(rst), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
      .wb_sel_i(sel[1]), .wb_adr_i(adr[1]), .wb_dat_i(dati[1]), .wb_dat_o(dato[1]),
      .wb_ack_o(ack[1]), .busy_o(busy[1])
`ifdef WBS_SRAM_ERR_EN
      , .wb_err_o(err[1])
`endif
   );
   wbs_sram #(.ADDR_WIDTH(AW), .WAIT_STATES(3)) u_ws3 (
      .clk(clk), .rst(rst), .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]), .wb_we_i(we[2]),
      .wb_sel_i(sel[2]), .wb_adr_i(adr[2]), .wb_dat_i(dati[2]), .wb_dat_o(dato[2]),
      .wb_ack_o(ack[2]), .busy_o(busy[2])
`ifdef WBS_SRAM_ERR_EN
      , .wb_err_o(err[2])
`endif
   );

`ifndef WBS_SRAM_ERR_EN
   assign err[0] = 1'b0;
   assign err[1] = 1'b0;
   assign err[2] = 1'b0;
`endif

   typedef struct {
      int          d;
      bit          w;
      logic [31:0] a;
      logic [3:0]  s;
      logic [31:0] dt;
      bit          e;
      logic [31:0] rd;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   // One complete transfer; exp_rd matters only for a read that is expected to ack.
   task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] dt, input bit exp_err, input logic [31:0] exp_rd);
      int          n;
      bit          done;
      logic [31:0] want;
      @(negedge clk);
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; dati[d] = dt;
      n = 0;
      done = 1'b0;
      while (!done && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (ack[d] || err[d]) done = 1'b1;
      end
      cyc[d] = 1'b0; stb[d] = 1'b0;
      chk("timeout", {31'b0, done}, 32'd1);
      chk("latency", 32'(n), 32'(ws_of[d] + 1));
      chk("ack", {31'b0, ack[d]}, {31'b0, !exp_err});
      chk("err", {31'b0, err[d]}, {31'b0, exp_err});
      chk("busy_ack", {31'b0, busy[d]}, 32'd1);
      want = (w || exp_err) ? last_rd[d] : exp_rd;
      chk("dat_o", dato[d], want);
      last_rd[d] = want;
      @(posedge clk); #1;
      chk("pulse", {30'b0, ack[d], err[d]}, 32'd0);
      chk("busy_idle", {31'b0, busy[d]}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit seen;
      int idx;
      bit w;
      logic [3:0]  s;
      logic [31:0] dt, a;

      for (int d = 0; d < 3; d++) begin
         cyc[d] = 0; stb[d] = 0; we[d] = 0; sel[d] = 0; adr[d] = 0; dati[d] = 0;
         last_rd[d] = 32'h0;
      end

      tbl[0] = '{1, 1'b1, 32'h40,   4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
      tbl[1] = '{1, 1'b0, 32'h40,   4'hF, 32'h0,        1'b0, 32'hDEADBEEF};
      tbl[2] = '{1, 1'b1, 32'h40,   4'h2, 32'h0000AB00, 1'b0, 32'h0};
      tbl[3] = '{1, 1'b0, 32'h40,   4'h0, 32'h0,        1'b0, 32'hDEADABEF};
      tbl[4] = '{1, 1'b0, 32'h43,   4'hF, 32'h0,        ERR_BUILD, 32'hDEADABEF};
      tbl[5] = '{1, 1'b0, 32'h4040, 4'hF, 32'h0,        ERR_BUILD, 32'hDEADABEF};
      tbl[6] = '{1, 1'b1, 32'h4040, 4'hF, 32'h11223344, ERR_BUILD, 32'h0};
      tbl[7] = '{1, 1'b0, 32'h40,   4'hF, 32'h0,        1'b0,
                 ERR_BUILD ? 32'hDEADABEF : 32'h11223344};

      #12;
      for (int d = 0; d < 3; d++) begin
         chk("rst_ack", {31'b0, ack[d]}, 32'd0);
         chk("rst_dat", dato[d], 32'h0);
         chk("rst_busy", {31'b0, busy[d]}, 32'd0);
      end
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 8; i++)
         xfer(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].dt, tbl[i].e, tbl[i].rd);

      // Abort on the 3-wait-state instance.
      xfer(2, 1'b1, 32'h40, 4'hF, 32'hDEADABEF, 1'b0, 32'h0);
      xfer(2, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, 32'hDEADABEF);
      @(negedge clk);
      cyc[2] = 1; stb[2] = 1; we[2] = 1; adr[2] = 32'h40; sel[2] = 4'hF; dati[2] = 32'h12345678;
      @(posedge clk); #1;
      chk("abort_busy_wait", {31'b0, busy[2]}, 32'd1);
      @(negedge clk);
      stb[2] = 0;
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (ack[2] || err[2]) seen = 1;
      end
      cyc[2] = 0;
      chk("abort_ack", {31'b0, seen}, 32'd0);
      chk("abort_busy", {31'b0, busy[2]}, 32'd0);
      chk("abort_dat", dato[2], 32'hDEADABEF);
      xfer(2, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, 32'hDEADABEF);

      // Zero-wait back-to-back reads with stb held.
      xfer(0, 1'b1, 32'h0, 4'hF, 32'hA5A50001, 1'b0, 32'h0);
      xfer(0, 1'b1, 32'h4, 4'hF, 32'h5A5A0002, 1'b0, 32'h0);
      @(negedge clk);
      cyc[0] = 1; stb[0] = 1; we[0] = 0; adr[0] = 32'h0; sel[0] = 4'hF;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); #1;
         chk("b2b_ack", {31'b0, ack[0]}, 32'(c % 2));
         chk("b2b_busy", {31'b0, busy[0]}, 32'(c % 2));
         if (c == 1) begin
            chk("b2b_dat0", dato[0], 32'hA5A50001);
            adr[0] = 32'h4;
         end
         if (c == 3) chk("b2b_dat1", dato[0], 32'h5A5A0002);
      end
      cyc[0] = 0; stb[0] = 0;
      last_rd[0] = 32'h5A5A0002;

      // Reset in the middle of a wait on the 3-wait-state instance.
      @(negedge clk);
      cyc[2] = 1; stb[2] = 1; we[2] = 1; adr[2] = 32'h40; sel[2] = 4'hF; dati[2] = 32'hFFFFFFFF;
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      chk("rstw_ack", {31'b0, ack[2]}, 32'd0);
      chk("rstw_dat", dato[2], 32'h0);
      chk("rstw_dat_ws0", dato[0], 32'h0);
      chk("rstw_busy", {31'b0, busy[2]}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      cyc[2] = 0; stb[2] = 0;
      rst = 1'b1;
      for (int d = 0; d < 3; d++) last_rd[d] = 32'h0;
      @(posedge clk); #1;
      chk("rstw_idle", {31'b0, busy[2]}, 32'd0);
      xfer(2, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, 32'hDEADABEF);
      xfer(1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, ERR_BUILD ? 32'hDEADABEF : 32'h11223344);

`ifdef WBS_SRAM_ERR_EN
      xfer(1, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0);
      xfer(1, 1'b0, 32'h42, 4'hF, 32'h0, 1'b1, 32'h0);
      xfer(1, 1'b1, 32'h1 << (AW + 2), 4'hF, 32'h0BADBAD0, 1'b1, 32'h0);
      xfer(1, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 32'hCAFEF00D);
`endif

      // Random traffic against a word-array model.
      for (int d = 0; d < 3; d++) begin
         for (int i = 0; i < 16; i++) begin
            mdl[d][i] = $urandom;
            xfer(d, 1'b1, 32'(i) << 2, 4'hF, mdl[d][i], 1'b0, 32'h0);
         end
         for (int k = 0; k < 50; k++) begin
            idx = $urandom_range(0, 15);
            w   = $urandom_range(0, 1) == 1;
            s   = 4'($urandom_range(0, 15));
            dt  = $urandom;
            a   = 32'(idx) << 2;
            if (!ERR_BUILD) a = a | 32'($urandom_range(0, 3)) | (32'($urandom_range(0, 3)) << (AW + 2));
            xfer(d, w, a, s, dt, 1'b0, mdl[d][idx]);
            if (w) begin
               for (int b = 0; b < 4; b++)
                  if (s[b]) mdl[d][idx][8*b +: 8] = dt[8*b +: 8];
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wbs_sram.md
Name: wbs_sram

Overview:
- Wishbone B3 classic single-cycle slave: the responder end of the instruction/data Wishbone master ports of the MiniMIPS32 core.
- Wraps an on-chip synchronous word RAM with byte-lane writes and a programmable wait-state counter.
- Sits behind the bus arbiter/decoder as a memory slave. Serves instruction fetch or data load/store from either master port.

Parameters:
- ADDR_WIDTH, 12, word-address bits; the RAM holds 2^ADDR_WIDTH 32-bit words.
- WAIT_STATES, 1, extra cycles inserted before ack; legal range 0..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe; a transfer is requested when cyc & stb.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_sel_i  in  4  byte-lane enables; bit n covers data[8n+7:8n].
- wb_adr_i  in  32  byte address.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  transfer-complete pulse.
- busy_o  out  1  high in WAIT or ACK state.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state=IDLE;
  - wb_ack_o=0, wb_dat_o=32'h0, busy_o=0;
  - wait counter=0.
  - RAM contents are not cleared.
  - Reset asserted mid-transfer abandons it with no write and no ack.
- Word index = wb_adr_i[ADDR_WIDTH+1:2]. Higher address bits and adr[1:0] are ignored, so addresses alias.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: when cyc&stb is sampled at edge E0, latch adr/we/sel/dat into request registers.
    - WAIT_STATES=0: go directly to ACK (perform access at E0).
    - Otherwise: go to WAIT and load the counter with WAIT_STATES-1.
  - WAIT: each edge, if cyc=0 or stb=0, go to IDLE (abort: no write, no ack, wb_dat_o unchanged).
    - Else if counter=0, go to ACK and perform the access at this edge.
    - Else decrement the counter.
  - ACK: wb_ack_o=1 for exactly this one cycle. Next edge always goes to IDLE. cyc/stb are ignored while in ACK.
- Access at the ACK-entering edge:
  - Write: each lane with latched sel[n]=1 updates that byte; lanes with sel[n]=0 keep the old byte. wb_dat_o unchanged.
  - Read: wb_dat_o <= RAM[word], the full 32 bits regardless of sel.
  - wb_dat_o holds its value until the next read ack.
- Latency: ack is visible in the cycle after edge E0+WAIT_STATES.
- Throughput: one transfer per WAIT_STATES+2 cycles. If the master still holds stb in the IDLE cycle after ACK, that is a new transfer. Back-to-back transfers are legal.
- Simultaneous change of request inputs during WAIT: ignored; the latched values are used.
- busy_o = (state != IDLE).

Optional Feature:
- Macro: WBS_SRAM_ERR_EN.
- Defined:
  - Adds output port wb_err_o (1 bit, reset 0).
  - A request is rejected if adr[1:0] != 0 or adr[31:ADDR_WIDTH+2] != 0.
  - A rejected request follows the same FSM and timing, but pulses wb_err_o instead of wb_ack_o, performs no write, and leaves wb_dat_o unchanged.
- Not defined: port wb_err_o is absent; aliasing applies as above and all requests ack.

Test Plan:
- Full write then read, WAIT_STATES=1:
  - write 32'hDEADBEEF to adr 0x40, sel 4'b1111 → ack in the second cycle after request sampling;
  - read adr 0x40 → wb_dat_o=32'hDEADBEEF with ack.
- Byte-lane write: after the above, write 32'h0000AB00 to adr 0x40 with sel 4'b0010 → read returns 32'hDEADABEF.
- Abort with WAIT_STATES=3: write 32'h12345678 to adr 0x40, drop stb after 1 WAIT cycle → no ack ever; a subsequent read returns 32'hDEADABEF.
- WAIT_STATES=0 back-to-back reads of 0x00 and 0x04, stb held high:
  - acks at cycles 1 and 3;
  - busy_o low exactly in cycles 2 and 4;
  - correct data on each ack.
- Reset during WAIT: assert rst=0 mid-wait → wb_ack_o=0 and wb_dat_o=0 immediately (asynchronously); after release, state=IDLE and earlier RAM contents are intact.
- WBS_SRAM_ERR_EN defined:
  - read adr 0x42 → wb_err_o one-cycle pulse, wb_ack_o stays 0;
  - write to adr 1<<(ADDR_WIDTH+2) → err pulse, and word 0 is unchanged.
